// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU and a multi-cycle multiply/divide unit owning HI/LO.
// Optional EX_MD_CANCEL_EN adds md_cancel, which aborts an in-flight mult/div (exception flush).
module ex_stage_md #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rs_e,
    input  logic [DATA_W-1:0] rt_e,
    input  logic [DATA_W-1:0] ext_e,
    input  logic [DATA_W-1:0] alu_m,
    input  logic [DATA_W-1:0] pc8_m,
    input  logic [DATA_W-1:0] wd_w,
    input  logic [2:0]        fwd_rs,
    input  logic [2:0]        fwd_rt,
    input  logic              alu_src,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        md_op,
`ifdef EX_MD_CANCEL_EN
    input  logic              md_cancel,
`endif
    input  logic [1:0]        res_sel,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] rt_fwd,
    output logic              md_busy,
    output logic              md_stall
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   rs_fwd;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_y;
    logic [SH_W-1:0]     shamt;

    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                md_is_div;
    logic                md_signed;
    logic [7:0]          cnt;
    logic                cancel;

    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] prod;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W-1:0]   div_b;
    logic [DATA_W-1:0]   q_mag;
    logic [DATA_W-1:0]   r_mag;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;
    logic                div_ok;

`ifdef EX_MD_CANCEL_EN
    assign cancel = md_cancel;
`else
    assign cancel = 1'b0;
`endif

    always_comb begin
        rs_fwd = rs_e;
        case (fwd_rs)
            3'd1:    rs_fwd = alu_m;
            3'd2:    rs_fwd = pc8_m;
            3'd3:    rs_fwd = wd_w;
            default: rs_fwd = rs_e;
        endcase
    end

    always_comb begin
        rt_fwd = rt_e;
        case (fwd_rt)
            3'd1:    rt_fwd = alu_m;
            3'd2:    rt_fwd = pc8_m;
            3'd3:    rt_fwd = wd_w;
            default: rt_fwd = rt_e;
        endcase
    end

    assign alu_a = rs_fwd;
    assign alu_b = alu_src ? ext_e : rt_fwd;
    assign shamt = alu_a[SH_W-1:0];

    // Shifts take the amount from A and shift B, matching MIPS sllv/srlv/srav.
    always_comb begin
        alu_y = '0;
        case (alu_op)
            4'd0:    alu_y = alu_a + alu_b;
            4'd1:    alu_y = alu_a - alu_b;
            4'd2:    alu_y = alu_a & alu_b;
            4'd3:    alu_y = alu_a | alu_b;
            4'd4:    alu_y = alu_a ^ alu_b;
            4'd5:    alu_y = ~(alu_a | alu_b);
            4'd6:    alu_y = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'd7:    alu_y = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
            4'd8:    alu_y = alu_b << shamt;
            4'd9:    alu_y = alu_b >> shamt;
            4'd10:   alu_y = $signed(alu_b) >>> shamt;
            4'd11:   alu_y = alu_b << (DATA_W/2);
            default: alu_y = '0;
        endcase
    end

    // Extending both operands to 2*DATA_W lets one unsigned multiplier serve mult and multu.
    assign ext_a = {{DATA_W{md_signed & op_a[DATA_W-1]}}, op_a};
    assign ext_b = {{DATA_W{md_signed & op_b[DATA_W-1]}}, op_b};
    assign prod  = ext_a * ext_b;

    // Sign-magnitude division; MIN / -1 falls out naturally as quotient MIN, remainder 0.
    assign neg_a  = md_signed & op_a[DATA_W-1];
    assign neg_b  = md_signed & op_b[DATA_W-1];
    assign abs_a  = neg_a ? -op_a : op_a;
    assign abs_b  = neg_b ? -op_b : op_b;
    assign div_ok = (op_b != '0);
    assign div_b  = div_ok ? abs_b : {{(DATA_W-1){1'b0}}, 1'b1};
    assign q_mag  = abs_a / div_b;
    assign r_mag  = abs_a % div_b;
    assign quot   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem    = neg_a ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            md_is_div <= 1'b0;
            md_signed <= 1'b0;
            cnt       <= 8'd0;
            md_busy   <= 1'b0;
        end else if (md_busy) begin
            if (cancel) begin
                cnt     <= 8'd0;
                md_busy <= 1'b0;
            end else begin
                cnt <= cnt - 8'd1;
                if (cnt == 8'd1) begin
                    md_busy <= 1'b0;
                    if (!md_is_div) begin
                        {hi, lo} <= prod;
                    end else if (div_ok) begin
                        hi <= rem;
                        lo <= quot;
                    end
                end
            end
        end else begin
            case (md_op)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    if (!cancel) begin
                        op_a      <= rs_fwd;
                        op_b      <= rt_fwd;
                        md_is_div <= (md_op >= 3'd3);
                        md_signed <= (md_op == 3'd1) || (md_op == 3'd3);
                        cnt       <= (md_op <= 3'd2) ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
                        md_busy   <= 1'b1;
                    end
                end
                3'd5:    hi <= rs_fwd;
                3'd6:    lo <= rs_fwd;
                default: ;
            endcase
        end
    end

    always_comb begin
        ex_result = alu_y;
        case (res_sel)
            2'd1:    ex_result = hi;
            2'd2:    ex_result = lo;
            default: ex_result = alu_y;
        endcase
    end

    assign md_stall = md_busy | (md_op != 3'd0) | (((res_sel == 2'd1) || (res_sel == 2'd2)) && md_busy);

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU/forwarding vector table plus mult/div sequences.
// Define EX_MD_CANCEL_EN for both this file and the RTL to exercise md_cancel.
module tb_ex_stage_md;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rs_e, rt_e, ext_e, alu_m, pc8_m, wd_w;
    logic [2:0]  fwd_rs, fwd_rt;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic [1:0]  res_sel;
`ifdef EX_MD_CANCEL_EN
    logic        md_cancel;
`endif
    logic [31:0] ex_result, rt_fwd;
    logic        md_busy, md_stall;

    int checks = 0;
    int errors = 0;

    ex_stage_md #(.DATA_W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_e      (rs_e),
        .rt_e      (rt_e),
        .ext_e     (ext_e),
        .alu_m     (alu_m),
        .pc8_m     (pc8_m),
        .wd_w      (wd_w),
        .fwd_rs    (fwd_rs),
        .fwd_rt    (fwd_rt),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .md_op     (md_op),
`ifdef EX_MD_CANCEL_EN
        .md_cancel (md_cancel),
`endif
        .res_sel   (res_sel),
        .ex_result (ex_result),
        .rt_fwd    (rt_fwd),
        .md_busy   (md_busy),
        .md_stall  (md_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fs;
        logic [2:0]  ft;
        logic        src;
        logic [3:0]  op;
        logic [1:0]  rsel;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [31:0] exp_res;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        fwd_rs  = v.fs;
        fwd_rt  = v.ft;
        alu_src = v.src;
        alu_op  = v.op;
        res_sel = v.rsel;
        rs_e    = v.rs;
        rt_e    = v.rt;
        ext_e   = v.ext;
        md_op   = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        fwd_rs  = 3'd0;
        fwd_rt  = 3'd0;
        rs_e    = a;
        rt_e    = b;
        res_sel = 2'd0;
        md_op   = op;
        #1;
        checkOutput("stall on op", {31'b0, md_stall}, 32'd1);
        step();
        md_op = 3'd0;
    endtask

    // Busy must stay high for exactly n cycles after the start edge.
    task automatic runBusy(input int n, input string name);
        for (int k = 1; k <= n; k++) begin
            #1;
            checkOutput(name, {31'b0, md_busy}, 32'd1);
            step();
        end
        checkOutput(name, {31'b0, md_busy}, 32'd0);
    endtask

    task automatic readHiLo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        res_sel = 2'd1;
        #1;
        checkOutput(name, ex_result, exp_hi);
        res_sel = 2'd2;
        #1;
        checkOutput(name, ex_result, exp_lo);
        res_sel = 2'd0;
    endtask

    initial begin
        reset   = 1'b1;
        rs_e    = '0;
        rt_e    = '0;
        ext_e   = '0;
        alu_m   = 32'd7;
        pc8_m   = 32'h0000_0100;
        wd_w    = 32'h8000_0000;
        fwd_rs  = '0;
        fwd_rt  = '0;
        alu_src = 1'b0;
        alu_op  = '0;
        md_op   = '0;
        res_sel = '0;
`ifdef EX_MD_CANCEL_EN
        md_cancel = 1'b0;
`endif

        //          fs    ft    src   op     rsel  rs            rt            ext           exp_res       exp_rt
        vecs[0]  = '{3'd1, 3'd0, 1'b1, 4'd0,  2'd0, 32'd3,        32'd0,        32'd5,        32'd12,       32'd0};
        vecs[1]  = '{3'd5, 3'd0, 1'b1, 4'd0,  2'd0, 32'd3,        32'd0,        32'd5,        32'd8,        32'd0};
        vecs[2]  = '{3'd2, 3'd3, 1'b0, 4'd1,  2'd0, 32'd0,        32'd0,        32'd0,        32'h80000100, 32'h80000000};
        vecs[3]  = '{3'd0, 3'd0, 1'b0, 4'd2,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hF000F000, 32'hFF00FF00};
        vecs[4]  = '{3'd0, 3'd0, 1'b0, 4'd3,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hFFF0FFF0, 32'hFF00FF00};
        vecs[5]  = '{3'd0, 3'd0, 1'b0, 4'd4,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0FF00FF0, 32'hFF00FF00};
        vecs[6]  = '{3'd0, 3'd0, 1'b0, 4'd5,  2'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h000F000F, 32'hFF00FF00};
        vecs[7]  = '{3'd0, 3'd0, 1'b0, 4'd6,  2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        32'd1};
        vecs[8]  = '{3'd0, 3'd0, 1'b0, 4'd7,  2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd1};
        vecs[9]  = '{3'd0, 3'd0, 1'b0, 4'd8,  2'd0, 32'h24,       32'hF,        32'd0,        32'hF0,       32'hF};
        vecs[10] = '{3'd0, 3'd0, 1'b0, 4'd9,  2'd0, 32'd4,        32'h80000000, 32'd0,        32'h08000000, 32'h80000000};
        vecs[11] = '{3'd0, 3'd0, 1'b0, 4'd10, 2'd0, 32'd4,        32'h80000000, 32'd0,        32'hF8000000, 32'h80000000};
        vecs[12] = '{3'd0, 3'd0, 1'b1, 4'd11, 2'd0, 32'd9,        32'd0,        32'h1234,     32'h12340000, 32'd0};
        vecs[13] = '{3'd0, 3'd0, 1'b0, 4'd12, 2'd0, 32'd5,        32'd6,        32'd0,        32'd0,        32'd6};
        vecs[14] = '{3'd0, 3'd0, 1'b0, 4'd0,  2'd0, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd1,        32'd2};
        vecs[15] = '{3'd7, 3'd1, 1'b0, 4'd0,  2'd3, 32'd10,       32'd99,       32'd0,        32'd17,       32'd7};
        vecs[16] = '{3'd0, 3'd0, 1'b0, 4'd1,  2'd0, 32'd0,        32'd1,        32'd0,        32'hFFFFFFFF, 32'd1};

        step();
        step();
        reset = 1'b0;
        #1;
        checkOutput("reset busy", {31'b0, md_busy}, 32'd0);
        checkOutput("reset stall", {31'b0, md_stall}, 32'd0);
        readHiLo(32'd0, 32'd0, "reset hilo");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("alu vec %0d result", i), ex_result, vecs[i].exp_res);
            checkOutput($sformatf("alu vec %0d rt_fwd", i), rt_fwd, vecs[i].exp_rt);
        end
        alu_src = 1'b0;
        alu_op  = 4'd0;
        step();

        startOp(3'd1, 32'hFFFFFFFE, 32'd3);
        runBusy(5, "mult busy");
        readHiLo(32'hFFFFFFFF, 32'hFFFFFFFA, "mult -2*3");

        startOp(3'd3, 32'hFFFFFFF9, 32'd2);
        runBusy(10, "div busy");
        readHiLo(32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");

        startOp(3'd4, 32'd5, 32'd0);
        runBusy(10, "divu0 busy");
        readHiLo(32'hFFFFFFFF, 32'hFFFFFFFD, "divu by zero");

        startOp(3'd3, 32'h80000000, 32'hFFFFFFFF);
        runBusy(10, "min div busy");
        readHiLo(32'd0, 32'h80000000, "div MIN/-1");

        startOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runBusy(5, "multu busy");
        readHiLo(32'hFFFFFFFE, 32'd1, "multu max");

        // mthi during a multu is dropped; mfhi is held off until the product lands.
        startOp(3'd2, 32'h00010000, 32'h00010000);
        res_sel = 2'd1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                md_op = 3'd5;
                rs_e  = 32'hDEADBEEF;
            end else begin
                md_op = 3'd0;
            end
            #1;
            checkOutput("mfhi stall", {31'b0, md_stall}, 32'd1);
            step();
        end
        md_op = 3'd0;
        #1;
        checkOutput("mfhi stall release", {31'b0, md_stall}, 32'd0);
        checkOutput("mfhi after mult", ex_result, 32'd1);
        readHiLo(32'd1, 32'd0, "mthi ignored");

        rs_e  = 32'h1234;
        md_op = 3'd6;
        step();
        md_op = 3'd0;
        #1;
        checkOutput("mtlo no busy", {31'b0, md_busy}, 32'd0);
        readHiLo(32'd1, 32'h1234, "mtlo");

        startOp(3'd3, 32'd100, 32'd7);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checkOutput("reset abort busy", {31'b0, md_busy}, 32'd0);
        readHiLo(32'd0, 32'd0, "reset abort");
        for (int k = 0; k < 12; k++) step();
        checkOutput("no late write busy", {31'b0, md_busy}, 32'd0);
        readHiLo(32'd0, 32'd0, "no late write");

`ifdef EX_MD_CANCEL_EN
        rs_e  = 32'hAAAA;
        md_op = 3'd5;
        step();
        rs_e  = 32'h5555;
        md_op = 3'd6;
        step();
        md_op = 3'd0;
        startOp(3'd1, 32'd3, 32'd4);
        step();
        md_cancel = 1'b1;
        step();
        md_cancel = 1'b0;
        #1;
        checkOutput("cancel busy", {31'b0, md_busy}, 32'd0);
        md_cancel = 1'b1;
        md_op     = 3'd1;
        step();
        md_cancel = 1'b0;
        md_op     = 3'd0;
        #1;
        checkOutput("cancel blocks start", {31'b0, md_busy}, 32'd0);
        for (int k = 0; k < 8; k++) step();
        readHiLo(32'hAAAA, 32'h5555, "cancel keeps hilo");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
